// File: rtl/draw_board.sv
// Board renderer: maps VGA timing onto a grid of square cells, fetches each cell's type from the
// board memory and produces the pixel colour. Two register stages; VGA timing travels alongside
// so vga_out and rgb stay aligned.
module draw_board #(
  parameter int unsigned CELL_PX      = 16,
  parameter int unsigned GRID_W       = 40,
  parameter int unsigned GRID_H       = 30,
  parameter int unsigned X0           = 0,
  parameter int unsigned Y0           = 0,
  parameter logic [11:0] BG_COLOR     = 12'hAAA,
  parameter logic [11:0] LINE_COLOR   = 12'h888,
  parameter logic [11:0] EMPTY_COLOR  = 12'hCCC,
  parameter logic [11:0] S1_COLOR     = 12'h0F0,
  parameter logic [11:0] S2_COLOR     = 12'h00F,
  parameter logic [11:0] FOOD_COLOR   = 12'hF00,
  parameter int unsigned BLINK_FRAMES = 16,
  localparam int unsigned XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int unsigned YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   vga_in_hcount,
  input  logic [10:0]   vga_in_vcount,
  input  logic          vga_in_hblnk,
  input  logic          vga_in_vblnk,
  input  logic          vga_in_hsync,
  input  logic          vga_in_vsync,
  output logic [10:0]   vga_out_hcount,
  output logic [10:0]   vga_out_vcount,
  output logic          vga_out_hblnk,
  output logic          vga_out_vblnk,
  output logic          vga_out_hsync,
  output logic          vga_out_vsync,
  output logic [11:0]   rgb,
  output logic [XW-1:0] cell_x,
  output logic [YW-1:0] cell_y,
  input  logic [1:0]    cell_type
);

  localparam int unsigned PW = $clog2(CELL_PX);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PxLast    = PW'(CELL_PX - 1);
  localparam logic [XW-1:0] XLast     = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YLast     = YW'(GRID_H - 1);
  localparam logic [FW-1:0] FrameLast = FW'(BLINK_FRAMES - 1);
  localparam logic [10:0]   HStart    = 11'(X0);
  localparam logic [10:0]   VStart    = 11'(Y0);

  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic [XW-1:0] cell_x_d;
  logic [YW-1:0] cell_y_d;
  logic          in_x_q, in_x_d, in_y_q, in_y_d;

  logic          s1_valid_q, s1_board_q, s1_line_q, s1_blank_q;
  logic [10:0]   s1_hcount_q, s1_vcount_q;
  logic          s1_hblnk_q, s1_vblnk_q, s1_hsync_q, s1_vsync_q;

  logic [FW-1:0] frame_q;
  logic          phase_q;

  logic [11:0]   empty_rgb, rgb_d;

  // Horizontal cell tracking: restart at the board's left edge, stop after the last cell.
  always_comb begin
    px_d     = px_q;
    cell_x_d = cell_x;
    in_x_d   = in_x_q;
    if (vga_in_hcount == HStart) begin
      px_d     = '0;
      cell_x_d = '0;
      in_x_d   = 1'b1;
    end else if (in_x_q) begin
      if (px_q == PxLast) begin
        if (cell_x == XLast) begin
          // Leave counters parked on the last cell so the address never exceeds the grid.
          in_x_d = 1'b0;
        end else begin
          px_d     = '0;
          cell_x_d = cell_x + 1'b1;
        end
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  // Vertical cell tracking, stepped once per line at hcount==0.
  always_comb begin
    py_d     = py_q;
    cell_y_d = cell_y;
    in_y_d   = in_y_q;
    if (vga_in_hcount == '0) begin
      if (vga_in_vcount == VStart) begin
        py_d     = '0;
        cell_y_d = '0;
        in_y_d   = 1'b1;
      end else if ((Y0 != 0) && (vga_in_vcount == '0)) begin
        in_y_d = 1'b0;
      end else if (in_y_q) begin
        if (py_q == PxLast) begin
          if (cell_y == YLast) begin
            in_y_d = 1'b0;
          end else begin
            py_d     = '0;
            cell_y_d = cell_y + 1'b1;
          end
        end else begin
          py_d = py_q + 1'b1;
        end
      end
    end
  end

  // Stage 1: register counters, board address and per-pixel flags with the timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q        <= '0;
      py_q        <= '0;
      cell_x      <= '0;
      cell_y      <= '0;
      in_x_q      <= 1'b0;
      in_y_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_board_q  <= 1'b0;
      s1_line_q   <= 1'b0;
      s1_blank_q  <= 1'b0;
      s1_hcount_q <= '0;
      s1_vcount_q <= '0;
      s1_hblnk_q  <= 1'b0;
      s1_vblnk_q  <= 1'b0;
      s1_hsync_q  <= 1'b0;
      s1_vsync_q  <= 1'b0;
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      cell_x      <= cell_x_d;
      cell_y      <= cell_y_d;
      in_x_q      <= in_x_d;
      in_y_q      <= in_y_d;
      s1_valid_q  <= 1'b1;
      s1_board_q  <= in_x_d & in_y_d;
      s1_line_q   <= (px_d == '0) | (py_d == '0);
      s1_blank_q  <= vga_in_hblnk | vga_in_vblnk;
      s1_hcount_q <= vga_in_hcount;
      s1_vcount_q <= vga_in_vcount;
      s1_hblnk_q  <= vga_in_hblnk;
      s1_vblnk_q  <= vga_in_vblnk;
      s1_hsync_q  <= vga_in_hsync;
      s1_vsync_q  <= vga_in_vsync;
    end
  end

  // Food blink: count frames at the frame origin, toggle phase on counter wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if ((vga_in_hcount == '0) && (vga_in_vcount == '0)) begin
      if (frame_q == FrameLast) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end

  // Stage 2 colour select; s1_valid suppresses the bubble left by reset.
  always_comb begin
    empty_rgb = s1_line_q ? LINE_COLOR : EMPTY_COLOR;
    rgb_d     = '0;
    if (!s1_valid_q || s1_blank_q) begin
      rgb_d = '0;
    end else if (!s1_board_q) begin
      rgb_d = BG_COLOR;
    end else begin
      unique case (cell_type)
        2'd1:    rgb_d = S1_COLOR;
        2'd2:    rgb_d = S2_COLOR;
        2'd3:    rgb_d = phase_q ? empty_rgb : FOOD_COLOR;
        default: rgb_d = empty_rgb;
      endcase
    end
  end

  // Stage 2: register colour together with the delayed timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb            <= '0;
      vga_out_hcount <= '0;
      vga_out_vcount <= '0;
      vga_out_hblnk  <= 1'b0;
      vga_out_vblnk  <= 1'b0;
      vga_out_hsync  <= 1'b0;
      vga_out_vsync  <= 1'b0;
    end else begin
      rgb            <= rgb_d;
      vga_out_hcount <= s1_hcount_q;
      vga_out_vcount <= s1_vcount_q;
      vga_out_hblnk  <= s1_hblnk_q;
      vga_out_vblnk  <= s1_vblnk_q;
      vga_out_hsync  <= s1_hsync_q;
      vga_out_vsync  <= s1_vsync_q;
    end
  end

endmodule
